regfile_write_arbiter: RTL

- Shares the single register-file write port between two requesters:
  - the pipeline writeback stage, which cannot stall;
  - an auxiliary multi-cycle result source (mult/div unit, late load return).
- Aux results are buffered in a small in-order FIFO and drained on cycles the WB stage leaves the port free.
- Sits between the MEM/WB pipeline register outputs and the register file.
- Also forms the WB result mux and raises a stall request when aux results starve.

---
 rtl/regfile_write_arbiter_if.sv | 31 +++
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - WB/aux requester and register-file port bundle for the write arbiter
interface regfile_write_arbiter_if #(
    parameter int DEPTH = 4
) ();
    logic                     RegWW;
    logic                     MemToRegW;
    logic [31:0]              ReadDataW;
    logic [31:0]              ALUOutW;
    logic [4:0]               WriteRegW;
    logic                     AuxValid;
    logic                     AuxReady;
    logic [4:0]               AuxReg;
    logic [31:0]              AuxData;
    logic                     RegWriteEn;
    logic [4:0]               RegWriteAddr;
    logic [31:0]              RegWriteData;
    logic                     StallReq;
    logic [$clog2(DEPTH):0]   AuxCount;

    modport master (
        output RegWW, MemToRegW, ReadDataW, ALUOutW, WriteRegW,
        output AuxValid, AuxReg, AuxData,
        input  AuxReady, RegWriteEn, RegWriteAddr, RegWriteData, StallReq, AuxCount
    );

    modport slave (
        input  RegWW, MemToRegW, ReadDataW, ALUOutW, WriteRegW,
        input  AuxValid, AuxReg, AuxData,
        output AuxReady, RegWriteEn, RegWriteAddr, RegWriteData, StallReq, AuxCount
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port arbiter: WB has priority, aux results drain from an in-order FIFO
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]       reg_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       wait_q, wait_d;

    logic        wb_claim;
    logic [31:0] result_w;
    logic        fifo_empty;
    logic        head_live;
    logic        aux_ready;
    logic        push;
    logic        pop;

    assign result_w   = bus.MemToRegW ? bus.ReadDataW : bus.ALUOutW;
    assign wb_claim   = bus.RegWW && (bus.WriteRegW != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign head_live  = !fifo_empty && live_q[head_q];

    // Ready looks only at the registered count, keeping RegWW off the AuxReady path.
    assign aux_ready  = reset && (count_q < CW'(DEPTH));
    assign push       = bus.AuxValid && aux_ready && (bus.AuxReg != 5'd0);
    assign pop        = !fifo_empty && (!live_q[head_q] || !wb_claim);

    always_comb begin
        bus.RegWriteEn   = 1'b0;
        bus.RegWriteAddr = 5'd0;
        bus.RegWriteData = 32'd0;
        if (reset) begin
            if (wb_claim) begin
                bus.RegWriteEn   = 1'b1;
                bus.RegWriteAddr = bus.WriteRegW;
                bus.RegWriteData = result_w;
            end else if (head_live) begin
                bus.RegWriteEn   = 1'b1;
                bus.RegWriteAddr = reg_q[head_q];
                bus.RegWriteData = data_q[head_q];
            end
        end
    end

    assign bus.AuxReady = aux_ready;
    assign bus.StallReq = reset && head_live && (wait_q >= 4'(STARVE_LIMIT));
    assign bus.AuxCount = count_q;

    // Squash is applied before the push so a same-cycle aux entry survives as the younger write.
    always_comb begin
        live_d = live_q;
        if (wb_claim) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (reg_q[i] == bus.WriteRegW) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_d[head_q] = 1'b0;
        end
        if (push) begin
            live_d[tail_q] = 1'b1;
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        wait_d  = wait_q;
        if (pop || fifo_empty) begin
            wait_d = 4'd0;
        end else if (head_live && wb_claim && (wait_q != 4'hF)) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

    // Payload storage needs no reset; the live bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[tail_q]  <= bus.AuxReg;
            data_q[tail_q] <= bus.AuxData;
        end
    end
endmodule
